// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared definitions for the digit-serial subtractor.
//   WORD_W        - operand / result width (32)
//   state_t       - control state encoding (IDLE, RUN, DONE)
//   digit_w_legal - true when a DIGIT_W value evenly splits the word into
//                   power-of-two digits (1, 2, 4, 8, 16, 32)
package serial_sub_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic bit digit_w_legal(input int w);
    return (w == 1) || (w == 2) || (w == 4) || (w == 8) || (w == 16) || (w == 32);
  endfunction

endpackage

// File: rtl/serial_sub_if.sv
// serial_sub_if: request/result bundle of the digit-serial subtractor.
//   start, A, B                       - request side (master drives)
//   busy, done, Diff, Borrow,
//   Overflow, Zero, Negative          - result side (slave drives)
//   Less                              - signed A < B, only when SERIAL_SUB_SLT_EN
//                                       is defined
// Modports: master (requester), slave (subtractor).
interface serial_sub_if;
  import serial_sub_pkg::*;

  logic              start;
  logic [WORD_W-1:0] A;
  logic [WORD_W-1:0] B;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] Diff;
  logic              Borrow;
  logic              Overflow;
  logic              Zero;
  logic              Negative;
`ifdef SERIAL_SUB_SLT_EN
  logic              Less;

  modport master (
    output start, A, B,
    input  busy, done, Diff, Borrow, Overflow, Zero, Negative, Less
  );

  modport slave (
    input  start, A, B,
    output busy, done, Diff, Borrow, Overflow, Zero, Negative, Less
  );
`else
  modport master (
    output start, A, B,
    input  busy, done, Diff, Borrow, Overflow, Zero, Negative
  );

  modport slave (
    input  start, A, B,
    output busy, done, Diff, Borrow, Overflow, Zero, Negative
  );
`endif

endinterface

// File: rtl/serial_sub_sub_digit.sv
// sub_digit: combinational W-bit ripple subtractor built from one-bit full
// subtractors, computing i_a - i_b - i_bin.
//   i_a, i_b  - digit operands (W bits)
//   i_bin     - borrow in
//   o_d       - difference digit (W bits)
//   o_bout    - borrow out of the most significant bit
module sub_digit #(
  parameter int W = 1
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_bin,
  output logic [W-1:0] o_d,
  output logic         o_bout
);

  logic [W:0] w_bor;

  assign w_bor[0] = i_bin;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign o_d[gi]       = i_a[gi] ^ i_b[gi] ^ w_bor[gi];
    // Borrow when b exceeds a, or when they match and a borrow arrives.
    assign w_bor[gi + 1] = (~i_a[gi] & i_b[gi]) | (~(i_a[gi] ^ i_b[gi]) & w_bor[gi]);
  end

  assign o_bout = w_bor[W];

endmodule

// File: rtl/serial_sub.sv
// serial_sub: multi-cycle 32-bit subtractor (Diff = A - B), DIGIT_W bits per
// clock, LSB first, with the borrow registered between digits.
//   clk    - rising-edge clock
//   reset  - synchronous, active-high reset
//   bus    - serial_sub_if.slave: start/A/B in; busy/done/Diff/flags out
// Parameter DIGIT_W: 1, 2, 4, 8, 16 or 32 bits per step.
// Optional macro SERIAL_SUB_SLT_EN adds the Less flag (signed A < B).
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int DIGIT_W = 1
) (
  input  logic        clk,
  input  logic        reset,
  serial_sub_if.slave bus
);

  localparam int NSTEP  = WORD_W / DIGIT_W;
  localparam int STEP_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int LSB_W  = $clog2(WORD_W);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEP - 1);

  if (!digit_w_legal(DIGIT_W)) begin : g_bad_digit_w
    $error("serial_sub: DIGIT_W must be 1, 2, 4, 8, 16 or 32");
  end

  state_t              r_state;
  logic [STEP_W-1:0]   r_step;
  logic [WORD_W-1:0]   r_a;
  logic [WORD_W-1:0]   r_b;
  logic [WORD_W-1:0]   r_acc;   // partial difference, never exposed directly
  logic                r_bor;   // borrow carried between digits
  logic [WORD_W-1:0]   r_diff;
  logic                r_borrow;
  logic                r_ovf;
  logic                r_zero;
  logic                r_neg;
  logic                r_done;
`ifdef SERIAL_SUB_SLT_EN
  logic                r_less;
`endif

  logic [LSB_W-1:0]    w_lsb;
  logic [DIGIT_W-1:0]  w_a_dig;
  logic [DIGIT_W-1:0]  w_b_dig;
  logic [DIGIT_W-1:0]  w_d_dig;
  logic                w_bout;
  logic                w_ovf;

  assign w_lsb   = LSB_W'(int'(r_step) * DIGIT_W);
  assign w_a_dig = r_a[w_lsb +: DIGIT_W];
  assign w_b_dig = r_b[w_lsb +: DIGIT_W];

  sub_digit #(
    .W (DIGIT_W)
  ) u_sub_digit (
    .i_a    (w_a_dig),
    .i_b    (w_b_dig),
    .i_bin  (r_bor),
    .o_d    (w_d_dig),
    .o_bout (w_bout)
  );

  // Signed overflow: operand signs differ and the result sign left A's sign.
  assign w_ovf = (r_a[WORD_W-1] != r_b[WORD_W-1]) & (r_acc[WORD_W-1] != r_a[WORD_W-1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_step   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_bor    <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_done   <= 1'b0;
`ifdef SERIAL_SUB_SLT_EN
      r_less   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_bor   <= 1'b0;
            r_step  <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc[w_lsb +: DIGIT_W] <= w_d_dig;
          r_bor                   <= w_bout;
          if (r_step == LAST_STEP) begin
            r_step  <= '0;
            r_state <= DONE;
          end else begin
            r_step <= r_step + 1'b1;
          end
        end
        DONE: begin
          // Publish the complete result and flags in one step.
          r_done   <= 1'b1;
          r_diff   <= r_acc;
          r_borrow <= r_bor;
          r_ovf    <= w_ovf;
          r_zero   <= (r_acc == '0);
          r_neg    <= r_acc[WORD_W-1];
`ifdef SERIAL_SUB_SLT_EN
          r_less   <= r_acc[WORD_W-1] ^ w_ovf;
`endif
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (r_state == RUN);
  assign bus.done     = r_done;
  assign bus.Diff     = r_diff;
  assign bus.Borrow   = r_borrow;
  assign bus.Overflow = r_ovf;
  assign bus.Zero     = r_zero;
  assign bus.Negative = r_neg;
`ifdef SERIAL_SUB_SLT_EN
  assign bus.Less     = r_less;
`endif

endmodule
